apb_arbiter: RTL and testbench
==============================

APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of every requester and master-side address bus.
REQ-002 Parameter DATA_W, 32, width of write and read data buses.
REQ-003 PCLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 PRESET  input  1  reset, asynchronous and active-high.
REQ-005 req0_transfer/req1_transfer  input  1  single-cycle request pulse; qualifies the same requester's write, addr and wdata.
REQ-006 req0_write/req1_write  input  1  1 = write, 0 = read.
REQ-007 req0_addr/req1_addr  input  ADDR_W  transfer address.
REQ-008 req0_wdata/req1_wdata  input  DATA_W  write data.
REQ-009 req0_busy/req1_busy  output  1  high while that requester's request is pending or in flight.
REQ-010 req0_ready/req1_ready  output  1  registered single-cycle completion pulse.
REQ-011 req0_rdata/req1_rdata  output  DATA_W  captured read data; valid with ready and held until that requester's next completion.
REQ-012 m_transfer, m_write, m_addr, m_wdata  output  1/1/ADDR_W/DATA_W  request to the downstream APB master's internal port.
REQ-013 m_ready, m_rdata  input  1/DATA_W  completion and read data from the APB master; valid only in its ACCESS phase.

Function
REQ-014 Each requester SHALL own a one-deep pending slot; a transfer pulse while busy is low SHALL load write, addr and wdata into the slot and set busy on the next edge.
REQ-015 A transfer pulse while busy is high SHALL be ignored with no effect on any state.
REQ-016 FSM states: IDLE, ISSUE, SETUP_W, ACCESS_W.
REQ-017 IDLE: if any slot is pending, select a winner, latch its index and fields into the master-side registers, and go to ISSUE; otherwise stay in IDLE.
REQ-018 ISSUE: m_transfer SHALL be 1 for exactly this one cycle; next state SHALL be SETUP_W.
REQ-019 SETUP_W: this state lasts one cycle and mirrors the master's SETUP phase; m_ready SHALL be ignored here; next state SHALL be ACCESS_W.
REQ-020 ACCESS_W: stay while m_ready is 0; when m_ready is 1, capture m_rdata into the winner's rdata, pulse the winner's ready on the next cycle, clear the winner's busy on the same edge, and go to IDLE.
REQ-021 m_write, m_addr and m_wdata SHALL be stable from ISSUE through the completing ACCESS_W cycle.
REQ-022 m_transfer SHALL be 0 in every state other than ISSUE.
REQ-023 Tie-break in IDLE SHALL be round-robin: the requester not granted last wins, and the last-grant register SHALL update at each grant.
REQ-024 A lone pending requester SHALL win regardless of last grant.
REQ-025 Latency for a zero-wait slave: pulse in cycle 0, ISSUE in cycle 2, ready pulse in cycle 5. Each slave wait state SHALL add one cycle.
REQ-026 A new pulse from a requester in its ready cycle SHALL be accepted, because busy is already low in that cycle.
REQ-027 Write completions SHALL also update rdata with m_rdata.

Reset
REQ-028 On PRESET, the FSM SHALL go to IDLE, both slots SHALL clear, last-grant SHALL be 1 so requester 0 wins the first tie, and all outputs SHALL be 0.
REQ-029 Reset mid-transfer SHALL drop all pending and in-flight requests with no ready pulse.

Configuration
REQ-030 Macro APB_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win ties, and the last-grant register SHALL be omitted.
REQ-031 Macro APB_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-023.

Structure
REQ-032 Package apb_arb_pkg SHALL hold the FSM state enum, requester index constants REQ0=0 and REQ1=1, and NUM_REQ=2.
REQ-033 Sub-module apb_arb_slot SHALL implement one pending slot (capture, busy, clear) and SHALL be instantiated once per requester.

Verification
REQ-034 Single read: req0 read addr 0x1000_1004 with a zero-wait slave returning 0xDEAD_BEEF -> m_transfer high in cycle 2 only, req0_ready in cycle 5, req0_rdata 0xDEAD_BEEF.
REQ-035 Simultaneous requests after reset: req0 write 0x1000_0000 and req1 write 0x1000_2000 in the same cycle -> req0 issued first, req1 issued in the cycle after req0_ready's completing edge, and m_addr stable throughout each transfer.
REQ-036 Round-robin: both requesters re-request continuously for 4 transfers -> grant order 0,1,0,1. With APB_ARB_FIXED_PRIO_EN, req0 wins every tie.
REQ-037 Wait states: slave holds ready low for 3 ACCESS cycles -> ready pulse in cycle 8, and m_ready asserted during SETUP_W is ignored.
REQ-038 Busy drop: req1 pulses twice 2 cycles apart with addrs 0x1000_3000 and 0x1000_3004 -> only 0x1000_3000 issued, exactly one req1_ready.
REQ-039 Reset in ACCESS_W: assert PRESET while waiting -> all outputs 0 and busy 0, no ready pulse, next request serviced normally.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    SETUP_W  = 2'd2,
    ACCESS_W = 2'd3
  } arb_state_e;

  localparam int   NUM_REQ = 2;
  localparam logic REQ0    = 1'b0;
  localparam logic REQ1    = 1'b1;

  // Round-robin pick: on a tie the requester not granted last wins.
  function automatic logic rr_pick(input logic [NUM_REQ-1:0] pending,
                                   input logic               last_grant);
    if (pending[REQ0] && pending[REQ1]) return ~last_grant;
    return pending[REQ1] ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/apb_arb_slot.sv
// One-deep pending slot: captures a request while idle, holds it until the
// arbiter reports completion.
module apb_arb_slot #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              transfer,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear,
  output logic              busy,
  output logic              slot_write,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_wdata
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      busy       <= 1'b0;
      slot_write <= 1'b0;
      slot_addr  <= '0;
      slot_wdata <= '0;
    end else if (clear) begin
      busy <= 1'b0;
    end else if (transfer && !busy) begin
      busy       <= 1'b1;
      slot_write <= write;
      slot_addr  <= addr;
      slot_wdata <= wdata;
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester arbiter in front of an APB master's internal port.
// Define APB_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties).
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_transfer,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_busy,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_transfer,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_busy,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              m_transfer,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_e state_q, state_d;
  logic       grant, complete, winner, owner_q;

  logic [NUM_REQ-1:0] xfer_in, wr_in, busy, slot_write, slot_clear, ready_q;
  logic [ADDR_W-1:0]  addr_in    [NUM_REQ];
  logic [ADDR_W-1:0]  slot_addr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_in   [NUM_REQ];
  logic [DATA_W-1:0]  slot_wdata [NUM_REQ];
  logic [DATA_W-1:0]  rdata_q    [NUM_REQ];

  assign xfer_in        = {req1_transfer, req0_transfer};
  assign wr_in          = {req1_write, req0_write};
  assign addr_in[REQ0]  = req0_addr;
  assign addr_in[REQ1]  = req1_addr;
  assign wdata_in[REQ0] = req0_wdata;
  assign wdata_in[REQ1] = req1_wdata;
  assign slot_clear     = {complete & owner_q, complete & ~owner_q};

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_slot
    apb_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
      .PCLK       (PCLK),
      .PRESET     (PRESET),
      .transfer   (xfer_in[r]),
      .write      (wr_in[r]),
      .addr       (addr_in[r]),
      .wdata      (wdata_in[r]),
      .clear      (slot_clear[r]),
      .busy       (busy[r]),
      .slot_write (slot_write[r]),
      .slot_addr  (slot_addr[r]),
      .slot_wdata (slot_wdata[r])
    );
  end

`ifdef APB_ARB_FIXED_PRIO_EN
  assign winner = busy[REQ0] ? REQ0 : REQ1;
`else
  logic last_grant_q;

  assign winner = rr_pick(busy, last_grant_q);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)     last_grant_q <= REQ1;
    else if (grant) last_grant_q <= winner;
  end
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // In IDLE nothing is in flight, so busy equals "pending".
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would infer a latch.
    state_d  = state_q;
    grant    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|busy) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = SETUP_W;
      SETUP_W: state_d = ACCESS_W;
      ACCESS_W: begin
        if (m_ready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_transfer = (state_q == ISSUE);

  // Master-side fields are frozen from grant until the next grant.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      owner_q       <= REQ0;
      m_write       <= 1'b0;
      m_addr        <= '0;
      m_wdata       <= '0;
      ready_q       <= '0;
      rdata_q[REQ0] <= '0;
      rdata_q[REQ1] <= '0;
    end else begin
      ready_q <= '0;
      if (grant) begin
        owner_q <= winner;
        m_write <= slot_write[winner];
        m_addr  <= slot_addr[winner];
        m_wdata <= slot_wdata[winner];
      end
      if (complete) begin
        ready_q[owner_q] <= 1'b1;
        rdata_q[owner_q] <= m_rdata;
      end
    end
  end

  assign req0_busy  = busy[REQ0];
  assign req1_busy  = busy[REQ1];
  assign req0_ready = ready_q[REQ0];
  assign req1_ready = ready_q[REQ1];
  assign req0_rdata = rdata_q[REQ0];
  assign req1_rdata = rdata_q[REQ1];

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: transaction-level reference model,
// per-cycle compare, directed scenarios and randomized traffic.
module tb_apb_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              PCLK   = 1'b0;
  logic              PRESET = 1'b1;
  logic [1:0]        req_transfer = '0;
  logic [1:0]        req_write    = '0;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic              req0_busy, req1_busy, req0_ready, req1_ready;
  logic [DATA_W-1:0] req0_rdata, req1_rdata;
  logic              m_transfer, m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;

  always #5 PCLK = ~PCLK;

  apb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .req0_transfer (req_transfer[0]),
    .req0_write    (req_write[0]),
    .req0_addr     (req_addr[0]),
    .req0_wdata    (req_wdata[0]),
    .req0_busy     (req0_busy),
    .req0_ready    (req0_ready),
    .req0_rdata    (req0_rdata),
    .req1_transfer (req_transfer[1]),
    .req1_write    (req_write[1]),
    .req1_addr     (req_addr[1]),
    .req1_wdata    (req_wdata[1]),
    .req1_busy     (req1_busy),
    .req1_ready    (req1_ready),
    .req1_rdata    (req1_rdata),
    .m_transfer    (m_transfer),
    .m_write       (m_write),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_ready       (m_ready),
    .m_rdata       (m_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit                md_busy  [2];
  logic              md_wr    [2];
  logic [ADDR_W-1:0] md_addr  [2];
  logic [DATA_W-1:0] md_wdata [2];
  bit                e_ready  [2];
  logic [DATA_W-1:0] e_rdata  [2];
  logic              e_mw;
  logic [ADDR_W-1:0] e_ma;
  logic [DATA_W-1:0] e_md;
  bit                act;
  int                owner, last;
  longint            cyc = 0, issue_cyc = -10;
  bit                bq [2];

  function automatic int model_pick(input bit b0, input bit b1, input int last_g);
    if (b0 && b1) begin
`ifdef APB_ARB_FIXED_PRIO_EN
      return 0;
`else
      return 1 - last_g;
`endif
    end
    return b0 ? 0 : 1;
  endfunction

  // A grant in cycle g issues in g+1; the earliest completing cycle is g+3.
  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int r = 0; r < 2; r++) begin
        md_busy[r] = 0; md_wr[r] = 0; md_addr[r] = '0; md_wdata[r] = '0;
        e_ready[r] = 0; e_rdata[r] = '0;
      end
      act = 0; owner = 0; last = 1; e_mw = 0; e_ma = '0; e_md = '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        bq[r] = md_busy[r];
        e_ready[r] = 0;
      end
      if (act) begin
        if (cyc >= issue_cyc + 2 && m_ready) begin
          e_ready[owner] = 1;
          e_rdata[owner] = m_rdata;
          md_busy[owner] = 0;
          act = 0;
        end
      end else if (bq[0] || bq[1]) begin
        owner = model_pick(bq[0], bq[1], last);
        last = owner;
        act = 1;
        issue_cyc = cyc + 1;
        e_mw = md_wr[owner]; e_ma = md_addr[owner]; e_md = md_wdata[owner];
      end
      for (int r = 0; r < 2; r++) begin
        if (req_transfer[r] && !bq[r]) begin
          md_busy[r] = 1; md_wr[r] = req_write[r];
          md_addr[r] = req_addr[r]; md_wdata[r] = req_wdata[r];
        end
      end
      cyc++;
    end
  end

  always @(negedge PCLK) begin
    check("cmp_m_transfer", m_transfer, act && (cyc == issue_cyc));
    check("cmp_m_write",    m_write,    e_mw);
    check("cmp_m_addr",     m_addr,     e_ma);
    check("cmp_m_wdata",    m_wdata,    e_md);
    check("cmp_req0_busy",  req0_busy,  md_busy[0]);
    check("cmp_req1_busy",  req1_busy,  md_busy[1]);
    check("cmp_req0_ready", req0_ready, e_ready[0]);
    check("cmp_req1_ready", req1_ready, e_ready[1]);
    check("cmp_req0_rdata", req0_rdata, e_rdata[0]);
    check("cmp_req1_rdata", req1_rdata, e_rdata[1]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    req_transfer = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
  endtask

  task automatic drain();
    int k;
    req_transfer = '0;
    m_ready = 1'b1;
    k = 0;
    while ((req0_busy || req1_busy) && k < 200) begin
      next_cycle();
      k++;
    end
    check("drain_timeout", k < 200, 1'b1);
    repeat (2) next_cycle();
    m_ready = 1'b0;
  endtask

  // Lone request on an idle arbiter; m_ready is also raised in SETUP_W
  // with junk data, which must be ignored.
  task automatic run_single(input int r, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int waits,
                            input logic [31:0] rd, input string tag);
    req_transfer[r] = 1'b1; req_write[r] = wr; req_addr[r] = a; req_wdata[r] = wd;
    for (int c = 0; c <= 7 + waits; c++) begin
      m_ready = (c == 3) || (c >= 4 + waits);
      m_rdata = (c == 4 + waits) ? rd : $urandom;
      @(negedge PCLK);
      check({tag, "_xfer"}, m_transfer, c == 2);
      check({tag, "_ready"}, (r == 0) ? req0_ready : req1_ready, c == 5 + waits);
      check({tag, "_busy"}, (r == 0) ? req0_busy : req1_busy, c >= 1 && c <= 4 + waits);
      if (c >= 2 && c <= 4 + waits) begin
        check({tag, "_addr"}, m_addr, a);
        check({tag, "_write"}, m_write, wr);
      end
      if (c == 5 + waits)
        check({tag, "_rdata"}, (r == 0) ? req0_rdata : req1_rdata, rd);
      next_cycle();
      req_transfer[r] = 1'b0;
    end
    m_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[$];
    int n_rdy, n_xfer;
    logic [31:0] issued;
    int k;

    req_addr[0] = '0; req_addr[1] = '0; req_wdata[0] = '0; req_wdata[1] = '0;
    do_reset();

    // Reset state
    @(negedge PCLK);
    check("rst_m_transfer", m_transfer, 1'b0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_busy", {req1_busy, req0_busy}, 2'b00);
    check("rst_rdata0", req0_rdata, 32'h0);
    do_reset();

    // Single zero-wait read
    run_single(0, 1'b0, 32'h1000_1004, 32'h0, 0, 32'hDEAD_BEEF, "single_rd");
    // Three wait states on a req1 write
    run_single(1, 1'b1, 32'h1000_4000, 32'h1234_5678, 3, 32'hCAFE_0001, "wait3");
    check("rdata0_held", req0_rdata, 32'hDEAD_BEEF);

    // Simultaneous writes after reset
    do_reset();
    req_transfer = 2'b11; req_write = 2'b11;
    req_addr[0] = 32'h1000_0000; req_addr[1] = 32'h1000_2000;
    for (int c = 0; c <= 10; c++) begin
      m_ready = 1'b1;
      m_rdata = $urandom;
      @(negedge PCLK);
      check("sim_xfer", m_transfer, c == 2 || c == 6);
      check("sim_ready0", req0_ready, c == 5);
      check("sim_ready1", req1_ready, c == 9);
      if (c >= 2 && c <= 4) check("sim_addr0", m_addr, 32'h1000_0000);
      if (c >= 6 && c <= 8) check("sim_addr1", m_addr, 32'h1000_2000);
      next_cycle();
      req_transfer = '0;
    end

    // Second pulse while busy is dropped
    n_rdy = 0; n_xfer = 0; issued = '0;
    for (int c = 0; c <= 10; c++) begin
      req_transfer[1] = (c == 0) || (c == 2);
      req_write[1] = 1'b0;
      req_addr[1] = (c == 0) ? 32'h1000_3000 : 32'h1000_3004;
      m_ready = 1'b1;
      @(negedge PCLK);
      if (req1_ready) n_rdy++;
      if (m_transfer) begin n_xfer++; issued = m_addr; end
      next_cycle();
    end
    req_transfer = '0;
    check("drop_ready_count", n_rdy, 1);
    check("drop_xfer_count", n_xfer, 1);
    check("drop_addr", issued, 32'h1000_3000);
    check("drop_busy_after", req1_busy, 1'b0);

    // Reset while waiting in ACCESS_W
    req_transfer[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h1000_5000;
    req_wdata[0] = 32'hA5A5_A5A5; m_ready = 1'b0;
    next_cycle();
    req_transfer[0] = 1'b0;
    repeat (4) next_cycle();
    #2 PRESET = 1'b1;
    @(negedge PCLK);
    check("rstw_outputs", {m_transfer, m_write, req0_busy, req1_busy, req0_ready, req1_ready}, 6'b0);
    check("rstw_m_addr", m_addr, 32'h0);
    check("rstw_m_wdata", m_wdata, 32'h0);
    check("rstw_rdata", {req0_rdata, req1_rdata}, 64'h0);
    next_cycle();
    PRESET = 1'b0;
    m_ready = 1'b1;
    n_rdy = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge PCLK);
      if (req0_ready || req1_ready) n_rdy++;
      next_cycle();
    end
    check("rstw_no_ready", n_rdy, 0);
    m_ready = 1'b0;
    run_single(0, 1'b1, 32'h1000_5000, 32'h5A5A_5A5A, 1, 32'h0BAD_F00D, "after_rst");

    // Tie after a req0-only grant: round-robin favours req1, fixed favours req0
    req_transfer = 2'b11; req_write = 2'b00;
    req_addr[0] = 32'h1000_7000; req_addr[1] = 32'h2000_7000;
    for (int c = 0; c <= 10; c++) begin
      m_ready = 1'b1;
      @(negedge PCLK);
`ifdef APB_ARB_FIXED_PRIO_EN
      if (c == 2) check("tie_first", m_addr, 32'h1000_7000);
      if (c == 6) check("tie_second", m_addr, 32'h2000_7000);
`else
      if (c == 2) check("tie_first", m_addr, 32'h2000_7000);
      if (c == 6) check("tie_second", m_addr, 32'h1000_7000);
`endif
      next_cycle();
      req_transfer = '0;
    end

    // Continuous re-request: grant order 0,1,0,1
    do_reset();
    k = 0;
    while (grants.size() < 4 && k < 80) begin
      req_transfer[0] = !req0_busy; req_transfer[1] = !req1_busy;
      req_addr[0] = 32'h1000_0000 + 32'(k * 4);
      req_addr[1] = 32'h2000_0000 + 32'(k * 4);
      m_ready = $urandom_range(0, 1);
      m_rdata = $urandom;
      @(negedge PCLK);
      if (m_transfer) grants.push_back(m_addr[29] ? 1 : 0);
      next_cycle();
      k++;
    end
    check("rr_count", grants.size() >= 4, 1'b1);
    if (grants.size() >= 4) begin
      check("rr_g0", grants[0], 0);
      check("rr_g1", grants[1], 1);
      check("rr_g2", grants[2], 0);
      check("rr_g3", grants[3], 1);
    end
    drain();

    // Randomized traffic with one mid-run reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < 2; r++) begin
        req_transfer[r] = ($urandom_range(0, 99) < 40);
        req_write[r] = $urandom_range(0, 1);
        req_addr[r] = $urandom;
        req_wdata[r] = $urandom;
      end
      m_ready = $urandom_range(0, 1);
      m_rdata = $urandom;
      if (i == 1500) begin
        #2 PRESET = 1'b1;
        next_cycle();
        PRESET = 1'b0;
      end else begin
        next_cycle();
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
